// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding request FSM (IDLE/REQ/WAIT/HOLD)
// with redirect handling, a one-entry output buffer and a handshake counter.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] fetch_count
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      r_state;
  logic [63:0] r_pc;
  logic        r_kill;
  logic [63:0] r_fetch_count;
  logic [31:0] r_inst;
  logic [63:0] r_inst_pc;
  logic        r_inst_err;
  logic        r_req_valid;
  logic        r_inst_valid;

  logic [63:0] w_redirect_pc;

  // Fetch addresses are always word aligned.
  assign w_redirect_pc = {redirect_pc[63:2], 2'b00};

  // Fetch FSM: state, pc, kill flag, output buffer and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_kill        <= 1'b0;
      r_fetch_count <= 64'd0;
      r_inst        <= 32'd0;
      r_inst_pc     <= 64'd0;
      r_inst_err    <= 1'b0;
      r_req_valid   <= 1'b0;
      r_inst_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (redirect_valid) r_pc <= w_redirect_pc;
          r_state     <= StReq;
          r_req_valid <= 1'b1;
        end
        StReq: begin
          if (redirect_valid) r_pc <= w_redirect_pc;
          if (imem_req_ready) begin
            // The accepted request used the old pc; its response must be dropped.
            r_kill      <= redirect_valid;
            r_state     <= StWait;
            r_req_valid <= 1'b0;
          end
        end
        StWait: begin
          if (redirect_valid) r_pc <= w_redirect_pc;
          if (imem_rsp_valid) begin
            if (r_kill || redirect_valid) begin
              r_kill      <= 1'b0;
              r_state     <= StReq;
              r_req_valid <= 1'b1;
            end else begin
              r_inst       <= imem_rsp_data;
              r_inst_err   <= imem_rsp_err;
              r_inst_pc    <= r_pc;
              r_state      <= StHold;
              r_inst_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            r_kill <= 1'b1;
          end
        end
        StHold: begin
          if (redirect_valid || inst_ready) begin
            // A redirect wins over the sequential pc even when decode consumes.
            r_pc <= redirect_valid ? w_redirect_pc : r_pc + 64'd4;
            if (inst_ready) r_fetch_count <= r_fetch_count + 64'd1;
            r_state      <= StReq;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b1;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign inst_err       = r_inst_err;
  assign fetch_count    = r_fetch_count;

endmodule
